// File: rtl/instr_fetch_mem.sv
// Byte-addressed, big-endian instruction memory with a registered read pipeline,
// in-order response buffer with backpressure, fault flagging and a byte load port.
module instr_fetch_mem #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DEPTH_BYTES  = 256,
   parameter int unsigned WORD_BYTES   = 4,
   parameter int unsigned READ_LATENCY = 1,
   parameter bit          ALIGN_CHECK  = 1'b1,
   parameter              INIT_FILE    = "Ins2hex.txt"
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ReqValid,
   output logic                    ReqReady,
   input  logic [ADDR_WIDTH-1:0]   ReadAddress,
   output logic                    RespValid,
   input  logic                    RespReady,
   output logic [8*WORD_BYTES-1:0] Instruction,
   output logic                    Fault,
   input  logic                    LoadEn,
   output logic                    LoadReady,
   input  logic [ADDR_WIDTH-1:0]   LoadAddress,
   input  logic [7:0]              LoadData
);

   localparam int unsigned DATA_W    = 8 * WORD_BYTES;
   localparam int unsigned IDX_W     = $clog2(DEPTH_BYTES);
   localparam int unsigned BUF_DEPTH = READ_LATENCY + 1;
   localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
   localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);

   logic [7:0] mem [DEPTH_BYTES];

   logic [ADDR_WIDTH:0]   last_byte;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  rd_fault;
   logic [IDX_W-1:0]      base_idx;
   logic [DATA_W-1:0]     rd_data;

   // Widened by one bit so an address near the top of the space cannot wrap into range.
   assign last_byte    = {1'b0, ReadAddress} + (ADDR_WIDTH+1)'(WORD_BYTES - 1);
   assign misaligned   = ALIGN_CHECK && ((ReadAddress % ADDR_WIDTH'(WORD_BYTES)) != '0);
   assign out_of_range = last_byte >= (ADDR_WIDTH+1)'(DEPTH_BYTES);
   assign rd_fault     = misaligned || out_of_range;
   assign base_idx     = ReadAddress[IDX_W-1:0];

   always_comb begin
      rd_data = '0;
      if (!rd_fault) begin
         for (int i = 0; i < int'(WORD_BYTES); i++) begin
            rd_data[DATA_W-8-8*i +: 8] = mem[base_idx + IDX_W'(i)];
         end
      end
   end

   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [OCC_W-1:0]  buf_cnt_q, buf_cnt_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic              p_valid_q;
   logic              p_fault_q;
   logic [DATA_W-1:0] p_data_q;
   logic [DATA_W-1:0] buf_data_q  [BUF_DEPTH];
   logic              buf_fault_q [BUF_DEPTH];
   logic              accept;
   logic              pop;
   logic              push;
   logic              push_fault;
   logic [DATA_W-1:0] push_data;
   logic              load_in_range;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Occupancy counts in-flight plus buffered entries, so the buffer can never overflow.
   assign ReqReady  = rst_n && (occ_q < OCC_W'(BUF_DEPTH)) && !LoadEn;
   assign LoadReady = rst_n && (occ_q == '0);
   assign accept    = ReqValid && ReqReady;
   assign RespValid = (buf_cnt_q != '0);
   assign pop       = RespValid && RespReady;

   // With latency 1 the accept edge writes straight into the buffer; latency 2 adds one stage.
   assign push       = (READ_LATENCY == 1) ? accept   : p_valid_q;
   assign push_fault = (READ_LATENCY == 1) ? rd_fault : p_fault_q;
   assign push_data  = (READ_LATENCY == 1) ? rd_data  : p_data_q;

   assign Instruction = RespValid ? buf_data_q[rd_ptr_q]  : '0;
   assign Fault       = RespValid ? buf_fault_q[rd_ptr_q] : 1'b0;

   always_comb begin
      occ_d     = occ_q + OCC_W'(accept) - OCC_W'(pop);
      buf_cnt_d = buf_cnt_q + OCC_W'(push) - OCC_W'(pop);
      wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q     <= '0;
         buf_cnt_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         p_valid_q <= 1'b0;
         p_fault_q <= 1'b0;
         p_data_q  <= '0;
         for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            buf_data_q[i]  <= '0;
            buf_fault_q[i] <= 1'b0;
         end
      end else begin
         occ_q     <= occ_d;
         buf_cnt_q <= buf_cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         p_valid_q <= accept;
         p_fault_q <= rd_fault;
         p_data_q  <= rd_data;
         if (push) begin
            buf_data_q[wr_ptr_q]  <= push_data;
            buf_fault_q[wr_ptr_q] <= push_fault;
         end
      end
   end

   // Memory contents survive reset; out-of-range loads are dropped silently.
   assign load_in_range = {1'b0, LoadAddress} < (ADDR_WIDTH+1)'(DEPTH_BYTES);

   always_ff @(posedge clk) begin
      if (LoadEn && LoadReady && load_in_range) begin
         mem[LoadAddress[IDX_W-1:0]] <= LoadData;
      end
   end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem: three instances (latency 1, latency 2,
// latency 1 without alignment check) share stimulus; expectations are hand-computed.
module tb_instr_fetch_mem;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic [31:0] read_addr;
   logic        resp_ready;
   logic        load_en;
   logic [31:0] load_addr;
   logic [7:0]  load_data;

   logic        l1_req_ready, l1_resp_valid, l1_fault, l1_load_ready;
   logic [31:0] l1_instr;
   logic        l2_req_ready, l2_resp_valid, l2_fault, l2_load_ready;
   logic [31:0] l2_instr;
   logic        na_req_ready, na_resp_valid, na_fault, na_load_ready;
   logic [31:0] na_instr;

   int total = 0;
   int bad   = 0;

   instr_fetch_mem #(.ADDR_WIDTH(32), .DEPTH_BYTES(256), .WORD_BYTES(4),
                     .READ_LATENCY(1), .ALIGN_CHECK(1'b1), .INIT_FILE("")) u_l1 (
      .clk(clk), .rst_n(rst_n), .ReqValid(req_valid), .ReqReady(l1_req_ready),
      .ReadAddress(read_addr), .RespValid(l1_resp_valid), .RespReady(resp_ready),
      .Instruction(l1_instr), .Fault(l1_fault), .LoadEn(load_en),
      .LoadReady(l1_load_ready), .LoadAddress(load_addr), .LoadData(load_data));

   instr_fetch_mem #(.ADDR_WIDTH(32), .DEPTH_BYTES(256), .WORD_BYTES(4),
                     .READ_LATENCY(2), .ALIGN_CHECK(1'b1), .INIT_FILE("")) u_l2 (
      .clk(clk), .rst_n(rst_n), .ReqValid(req_valid), .ReqReady(l2_req_ready),
      .ReadAddress(read_addr), .RespValid(l2_resp_valid), .RespReady(resp_ready),
      .Instruction(l2_instr), .Fault(l2_fault), .LoadEn(load_en),
      .LoadReady(l2_load_ready), .LoadAddress(load_addr), .LoadData(load_data));

   instr_fetch_mem #(.ADDR_WIDTH(32), .DEPTH_BYTES(256), .WORD_BYTES(4),
                     .READ_LATENCY(1), .ALIGN_CHECK(1'b0), .INIT_FILE("")) u_na (
      .clk(clk), .rst_n(rst_n), .ReqValid(req_valid), .ReqReady(na_req_ready),
      .ReadAddress(read_addr), .RespValid(na_resp_valid), .RespReady(resp_ready),
      .Instruction(na_instr), .Fault(na_fault), .LoadEn(load_en),
      .LoadReady(na_load_ready), .LoadAddress(load_addr), .LoadData(load_data));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got running want finished");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [31:0] addr;
      logic [31:0] ins_a;
      logic        flt_a;
      logic [31:0] ins_n;
      logic        flt_n;
   } vec_t;

   vec_t vecs [12];

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
   } ld_t;

   ld_t pre [20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic read_l1(input logic [31:0] a, input logic [31:0] exp, input string nm);
      req_valid  = 1'b1;
      read_addr  = a;
      resp_ready = 1'b1;
      cyc();
      req_valid = 1'b0;
      #1;
      chk({nm, "_vld"}, {31'd0, l1_resp_valid}, 32'd1);
      chk(nm, l1_instr, exp);
      cyc();
      cyc();
   endtask

   initial begin
      vecs[0]  = '{32'd0,         32'h8C010004, 1'b0, 32'h8C010004, 1'b0};
      vecs[1]  = '{32'd4,         32'hAC020008, 1'b0, 32'hAC020008, 1'b0};
      vecs[2]  = '{32'd8,         32'h11223344, 1'b0, 32'h11223344, 1'b0};
      vecs[3]  = '{32'd12,        32'h55667788, 1'b0, 32'h55667788, 1'b0};
      vecs[4]  = '{32'd252,       32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
      vecs[5]  = '{32'd2,         32'h00000000, 1'b1, 32'h0004AC02, 1'b0};
      vecs[6]  = '{32'd9,         32'h00000000, 1'b1, 32'h22334455, 1'b0};
      vecs[7]  = '{32'd254,       32'h00000000, 1'b1, 32'h00000000, 1'b1};
      vecs[8]  = '{32'd253,       32'h00000000, 1'b1, 32'h00000000, 1'b1};
      vecs[9]  = '{32'd256,       32'h00000000, 1'b1, 32'h00000000, 1'b1};
      vecs[10] = '{32'hFFFFFFFC,  32'h00000000, 1'b1, 32'h00000000, 1'b1};
      vecs[11] = '{32'hFFFFFFFE,  32'h00000000, 1'b1, 32'h00000000, 1'b1};

      pre[0]  = '{32'd0,  8'h8C};  pre[1]  = '{32'd1,  8'h01};
      pre[2]  = '{32'd2,  8'h00};  pre[3]  = '{32'd3,  8'h04};
      pre[4]  = '{32'd4,  8'hAC};  pre[5]  = '{32'd5,  8'h02};
      pre[6]  = '{32'd6,  8'h00};  pre[7]  = '{32'd7,  8'h08};
      pre[8]  = '{32'd8,  8'h11};  pre[9]  = '{32'd9,  8'h22};
      pre[10] = '{32'd10, 8'h33};  pre[11] = '{32'd11, 8'h44};
      pre[12] = '{32'd12, 8'h55};  pre[13] = '{32'd13, 8'h66};
      pre[14] = '{32'd14, 8'h77};  pre[15] = '{32'd15, 8'h88};
      pre[16] = '{32'd252, 8'hDE}; pre[17] = '{32'd253, 8'hAD};
      pre[18] = '{32'd254, 8'hBE}; pre[19] = '{32'd255, 8'hEF};

      rst_n      = 1'b1;
      req_valid  = 1'b0;
      read_addr  = '0;
      resp_ready = 1'b0;
      load_en    = 1'b0;
      load_addr  = '0;
      load_data  = '0;

      // reset state
      #1 rst_n = 1'b0;
      #2;
      chk("rst_req_ready",  {31'd0, l1_req_ready},  32'd0);
      chk("rst_load_ready", {31'd0, l1_load_ready}, 32'd0);
      chk("rst_resp_valid", {31'd0, l1_resp_valid}, 32'd0);
      chk("rst_instr",      l1_instr,               32'd0);
      chk("rst_fault",      {31'd0, l1_fault},      32'd0);
      chk("rst_l2_valid",   {31'd0, l2_resp_valid}, 32'd0);
      @(posedge clk);
      #7 rst_n = 1'b1;
      #1;
      chk("rel_req_ready",  {31'd0, l1_req_ready},  32'd1);
      chk("rel_load_ready", {31'd0, l1_load_ready}, 32'd1);
      cyc();

      // program download: bytes 0..15, zeros at 16..47, DEADBEEF at 252..255
      for (int i = 0; i < 20; i++) begin
         load_en   = 1'b1;
         load_addr = pre[i].addr;
         load_data = pre[i].data;
         cyc();
      end
      for (int i = 16; i < 48; i++) begin
         load_en   = 1'b1;
         load_addr = 32'(i);
         load_data = 8'h00;
         cyc();
      end
      load_en = 1'b0;

      // single-request vectors, all three configurations
      for (int i = 0; i < 12; i++) begin
         req_valid  = 1'b1;
         read_addr  = vecs[i].addr;
         resp_ready = 1'b1;
         #1;
         chk($sformatf("v%0d_req_ready", i), {31'd0, l1_req_ready}, 32'd1);
         cyc();
         req_valid = 1'b0;
         #1;
         chk($sformatf("v%0d_l1_valid", i), {31'd0, l1_resp_valid}, 32'd1);
         chk($sformatf("v%0d_l1_instr", i), l1_instr, vecs[i].ins_a);
         chk($sformatf("v%0d_l1_fault", i), {31'd0, l1_fault}, {31'd0, vecs[i].flt_a});
         chk($sformatf("v%0d_na_valid", i), {31'd0, na_resp_valid}, 32'd1);
         chk($sformatf("v%0d_na_instr", i), na_instr, vecs[i].ins_n);
         chk($sformatf("v%0d_na_fault", i), {31'd0, na_fault}, {31'd0, vecs[i].flt_n});
         chk($sformatf("v%0d_l2_early", i), {31'd0, l2_resp_valid}, 32'd0);
         cyc();
         chk($sformatf("v%0d_l1_popped", i), {31'd0, l1_resp_valid}, 32'd0);
         chk($sformatf("v%0d_l2_valid", i), {31'd0, l2_resp_valid}, 32'd1);
         chk($sformatf("v%0d_l2_instr", i), l2_instr, vecs[i].ins_a);
         chk($sformatf("v%0d_l2_fault", i), {31'd0, l2_fault}, {31'd0, vecs[i].flt_a});
         cyc();
      end

      // back-to-back on latency 1
      req_valid  = 1'b1;
      read_addr  = 32'd0;
      resp_ready = 1'b1;
      cyc();
      read_addr = 32'd4;
      #1;
      chk("b2b_ready1", {31'd0, l1_req_ready},  32'd1);
      chk("b2b_valid1", {31'd0, l1_resp_valid}, 32'd1);
      chk("b2b_instr1", l1_instr, 32'h8C010004);
      cyc();
      req_valid = 1'b0;
      #1;
      chk("b2b_valid2", {31'd0, l1_resp_valid}, 32'd1);
      chk("b2b_instr2", l1_instr, 32'hAC020008);
      chk("b2b_ready2", {31'd0, l1_req_ready},  32'd1);
      cyc();
      chk("b2b_empty",  {31'd0, l1_resp_valid}, 32'd0);
      cyc();
      cyc();

      // latency 2 backpressure: three accepted, then held stable
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      read_addr  = 32'd0;
      #1;
      chk("bp_ready0", {31'd0, l2_req_ready}, 32'd1);
      cyc();
      read_addr = 32'd4;
      #1;
      chk("bp_ready1", {31'd0, l2_req_ready},  32'd1);
      chk("bp_valid1", {31'd0, l2_resp_valid}, 32'd0);
      cyc();
      read_addr = 32'd8;
      #1;
      chk("bp_ready2", {31'd0, l2_req_ready},  32'd1);
      chk("bp_valid2", {31'd0, l2_resp_valid}, 32'd1);
      chk("bp_instr2", l2_instr, 32'h8C010004);
      cyc();
      read_addr = 32'd12;
      #1;
      chk("bp_full", {31'd0, l2_req_ready}, 32'd0);
      for (int k = 0; k < 2; k++) begin
         cyc();
         chk($sformatf("bp_hold%0d_ready", k), {31'd0, l2_req_ready}, 32'd0);
         chk($sformatf("bp_hold%0d_valid", k), {31'd0, l2_resp_valid}, 32'd1);
         chk($sformatf("bp_hold%0d_instr", k), l2_instr, 32'h8C010004);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      #1;
      chk("bp_nocomb", {31'd0, l2_req_ready}, 32'd0);
      cyc();
      chk("bp_pop1_ready", {31'd0, l2_req_ready}, 32'd1);
      chk("bp_pop1_instr", l2_instr, 32'hAC020008);
      cyc();
      chk("bp_pop2_instr", l2_instr, 32'h11223344);
      cyc();
      chk("bp_drained", {31'd0, l2_resp_valid}, 32'd0);
      cyc();
      cyc();

      // load port: idle write of 12345678, then an out-of-range write
      for (int i = 0; i < 4; i++) begin
         load_en   = 1'b1;
         load_addr = 32'(i);
         load_data = 8'h12 + 8'(i) * 8'h22;
         #1;
         chk($sformatf("ld%0d_load_ready", i), {31'd0, l1_load_ready}, 32'd1);
         chk($sformatf("ld%0d_req_ready", i),  {31'd0, l1_req_ready},  32'd0);
         cyc();
      end
      load_en   = 1'b1;
      load_addr = 32'd300;
      load_data = 8'hFF;
      cyc();
      load_en = 1'b0;
      read_l1(32'd0,  32'h12345678, "ld_rd0");
      read_l1(32'd44, 32'h00000000, "ld_rd44");

      // load held off while two responses are buffered
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      read_addr  = 32'd8;
      cyc();
      read_addr = 32'd12;
      cyc();
      req_valid = 1'b0;
      load_en   = 1'b1;
      load_addr = 32'd20;
      load_data = 8'hEE;
      #1;
      chk("lb_load_ready0", {31'd0, l1_load_ready}, 32'd0);
      chk("lb_req_ready0",  {31'd0, l1_req_ready},  32'd0);
      chk("lb_head0",       l1_instr, 32'h11223344);
      cyc();
      chk("lb_load_ready1", {31'd0, l1_load_ready}, 32'd0);
      load_addr  = 32'd16;
      load_data  = 8'h5A;
      resp_ready = 1'b1;
      #1;
      chk("lb_load_ready2", {31'd0, l1_load_ready}, 32'd0);
      cyc();
      chk("lb_load_ready3", {31'd0, l1_load_ready}, 32'd0);
      chk("lb_head1",       l1_instr, 32'h55667788);
      cyc();
      chk("lb_load_ready4", {31'd0, l1_load_ready}, 32'd1);
      chk("lb_l2_ready4",   {31'd0, l2_load_ready}, 32'd1);
      cyc();
      load_en = 1'b0;
      read_l1(32'd16, 32'h5A000000, "lb_rd16");
      read_l1(32'd20, 32'h00000000, "lb_rd20");

      // asynchronous reset with two in flight
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      read_addr  = 32'd0;
      cyc();
      read_addr = 32'd4;
      cyc();
      req_valid = 1'b0;
      #1;
      chk("ar_before_valid", {31'd0, l1_resp_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid",      {31'd0, l1_resp_valid}, 32'd0);
      chk("ar_instr",      l1_instr,               32'd0);
      chk("ar_req_ready",  {31'd0, l1_req_ready},  32'd0);
      chk("ar_load_ready", {31'd0, l1_load_ready}, 32'd0);
      chk("ar_l2_valid",   {31'd0, l2_resp_valid}, 32'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      chk("ar_rel_ready", {31'd0, l1_req_ready},  32'd1);
      chk("ar_rel_load",  {31'd0, l1_load_ready}, 32'd1);
      resp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk($sformatf("ar_stale%0d_l1", k), {31'd0, l1_resp_valid}, 32'd0);
         chk($sformatf("ar_stale%0d_l2", k), {31'd0, l2_resp_valid}, 32'd0);
      end
      read_l1(32'd0, 32'h12345678, "ar_rd0");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
